// File: rtl/onehot_mux_pkg.sv
// Shared defaults and limits for the registered one-hot multiplexer.
package onehot_mux_pkg;

  localparam int unsigned ONEHOT_MUX_WIDTH_DEF = 4;
  localparam int unsigned ONEHOT_MUX_N_DEF     = 6;
  localparam int unsigned ONEHOT_MUX_CNT_W_DEF = 8;
  localparam int unsigned ONEHOT_MUX_N_MAX     = 32;

endpackage : onehot_mux_pkg

// File: rtl/onehot_mux_pipe_check.sv
// One-hot detector: true iff exactly one bit of vec is set.
// Clearing the lowest set bit (v & (v-1)) leaves zero only for powers of two.
module onehot_check #(
  parameter int unsigned N = 6
) (
  input  logic [N-1:0] vec,
  output logic         is_onehot
);

  logic [N-1:0] vec_m1;

  // Lowest-set-bit clear test, no popcount needed.
  always_comb begin
    vec_m1    = vec - N'(1);
    is_onehot = (vec != '0) && ((vec & vec_m1) == '0);
  end

endmodule : onehot_check

// File: rtl/onehot_mux_pipe.sv
// Registered N-input one-hot AND-OR multiplexer with valid/ready handshake.
// Optional non-one-hot checker and error tracking built when the macro
// ONEHOT_MUX_CHECK_EN is defined; otherwise the error outputs are tied to 0.
module onehot_mux_pipe
  import onehot_mux_pkg::*;
#(
  parameter int unsigned WIDTH = ONEHOT_MUX_WIDTH_DEF,
  parameter int unsigned N     = ONEHOT_MUX_N_DEF,
  parameter int unsigned CNT_W = ONEHOT_MUX_CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_err,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err_sticky,
  output logic [CNT_W-1:0]   err_count,
  input  logic               err_clr
);

  logic [WIDTH-1:0] sel_word;
  logic             accept;

  // AND-OR reduction: zero select gives 0, multiple selects OR their words.
  always_comb begin
    sel_word = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sel_word = sel_word | (in_data[i*WIDTH +: WIDTH] & {WIDTH{in_sel[i]}});
    end
  end

  // Stage can take a beat when empty or when the held beat leaves this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Output stage: load on accept, drop valid on drain, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_word;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ONEHOT_MUX_CHECK_EN

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic sel_onehot;
  logic beat_bad;

  onehot_check #(
    .N (N)
  ) u_check (
    .vec       (in_sel),
    .is_onehot (sel_onehot)
  );

  assign beat_bad = accept && !sel_onehot;

  // Per-beat error flag travels with the captured data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_err <= 1'b0;
    end else if (accept) begin
      out_err <= !sel_onehot;
    end
  end

  // Sticky flag and saturating counter; clear wins over a coincident error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else if (beat_bad) begin
      err_sticky <= 1'b1;
      if (err_count != CNT_MAX) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

`else

  logic unused_err_clr;

  assign out_err        = 1'b0;
  assign err_sticky     = 1'b0;
  assign err_count      = '0;
  assign unused_err_clr = err_clr;

`endif

endmodule : onehot_mux_pipe

// File: tb/tb_onehot_mux_pipe.sv
// Directed self-checking bench for onehot_mux_pipe (defaults WIDTH=4, N=6, CNT_W=8).
module tb_onehot_mux_pipe;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned N     = 6;
  localparam int unsigned CNT_W = 8;

`ifdef ONEHOT_MUX_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_sel;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_err;
  logic               out_valid;
  logic               out_ready;
  logic               err_sticky;
  logic [CNT_W-1:0]   err_count;
  logic               err_clr;

  int checks;
  int errors;

  onehot_mux_pipe #(
    .WIDTH (WIDTH),
    .N     (N),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_err    (out_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err_sticky (err_sticky),
    .err_count  (err_count),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_data   = '0;
    in_sel    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    checks++;
    if (out_data !== 4'h0 || out_err !== 1'b0 || err_count !== 8'd0 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: data=%h err=%b cnt=%0d sticky=%b want 0/0/0/0",
               out_data, out_err, err_count, err_sticky);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    in_data  = 24'hFEDCBA;
    in_sel   = 6'b001000;
    in_valid = 1'b1;
    step();
    checks++;
    if (out_data !== 4'hD || out_err !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_select: data=%h err=%b valid=%b want D/0/1", out_data, out_err, out_valid);
    end
  endtask

  task automatic test_invalid();
    in_sel = 6'b000000;
    step();
    checks++;
    if (out_data !== 4'h0 || out_err !== CHK || err_count !== 8'(CHK)) begin
      errors++;
      $display("FAIL sel_zero: data=%h err=%b cnt=%0d want 0/%b/%0d", out_data, out_err, err_count, CHK, CHK);
    end
    in_data = 24'hFEDCA5;
    in_sel  = 6'b000011;
    step();
    checks++;
    if (out_data !== 4'hF || out_err !== CHK || err_count !== (CHK ? 8'd2 : 8'd0) || err_sticky !== CHK) begin
      errors++;
      $display("FAIL sel_multi: data=%h err=%b cnt=%0d sticky=%b want F/%b/%0d/%b",
               out_data, out_err, err_count, err_sticky, CHK, CHK ? 2 : 0, CHK);
    end
  endtask

  task automatic test_backpressure();
    in_data = 24'hFEDCBA;
    in_sel  = 6'b000001;
    step();
    checks++;
    if (out_data !== 4'hA || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_load: data=%h valid=%b want A/1", out_data, out_valid);
    end
    out_ready = 1'b0;
    in_sel    = 6'b000010;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_data !== 4'hA || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: ready=%b data=%h valid=%b want 0/A/1", i, in_ready, out_data, out_valid);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready);
    end
    step();
    checks++;
    if (out_data !== 4'hB || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_replace: data=%h valid=%b want B/1", out_data, out_valid);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'hB) begin
      errors++; $display("FAIL drain: valid=%b data=%h want 0/B", out_valid, out_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0]     sels [4];
    logic [WIDTH-1:0] exps [4];
    sels[0] = 6'b100000; exps[0] = 4'hF;
    sels[1] = 6'b000100; exps[1] = 4'hC;
    sels[2] = 6'b010000; exps[2] = 4'hE;
    sels[3] = 6'b000001; exps[3] = 4'hA;
    in_data  = 24'hFEDCBA;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sel = sels[i];
      step();
      checks++;
      if (out_data !== exps[i] || out_valid !== 1'b1 || out_err !== 1'b0) begin
        errors++;
        $display("FAIL b2b%0d: data=%h valid=%b err=%b want %h/1/0", i, out_data, out_valid, out_err, exps[i]);
      end
    end
  endtask

  task automatic test_counter();
    in_sel   = 6'b000000;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) step();
    checks++;
    if (err_count !== (CHK ? 8'd255 : 8'd0) || err_sticky !== CHK) begin
      errors++;
      $display("FAIL cnt_saturate: cnt=%0d sticky=%b want %0d/%b", err_count, err_sticky, CHK ? 255 : 0, CHK);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if (err_count !== 8'd0 || err_sticky !== 1'b0) begin
      errors++; $display("FAIL cnt_clear: cnt=%0d sticky=%b want 0/0", err_count, err_sticky);
    end
    step();
    checks++;
    if (err_count !== 8'(CHK) || err_sticky !== CHK) begin
      errors++; $display("FAIL cnt_after_clear: cnt=%0d sticky=%b want %0d/%b", err_count, err_sticky, CHK, CHK);
    end
  endtask

  task automatic test_reset_mid();
    in_data  = 24'hFEDCBA;
    in_sel   = 6'b000000;
    in_valid = 1'b1;
    step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || err_count !== 8'd0 || err_sticky !== 1'b0 || out_data !== 4'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: valid=%b cnt=%0d sticky=%b data=%h ready=%b want 0/0/0/0/1",
               out_valid, err_count, err_sticky, out_data, in_ready);
    end
    step();
    rst    = 1'b0;
    in_sel = 6'b100000;
    step();
    checks++;
    if (out_data !== 4'hF || out_valid !== 1'b1 || out_err !== 1'b0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL post_reset_accept: data=%h valid=%b err=%b cnt=%0d want F/1/0/0",
               out_data, out_valid, out_err, err_count);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_invalid();
    test_backpressure();
    test_back_to_back();
    test_counter();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_onehot_mux_pipe

// File: doc/onehot_mux_pipe.md
# onehot_mux_pipe

Parametrised, registered one-hot multiplexer with a valid/ready handshake. It replaces the fixed 6-input, 4-bit AND-OR one-hot selector with a generic N-input, WIDTH-bit version. The selected word is captured into a single pipeline stage. An optional checker flags select vectors that are not one-hot. The block sits between a source that presents all candidate words plus a one-hot select, and a downstream consumer that may apply backpressure.

## Interface
Parameters:
- WIDTH, 4, bits per input word and per output word (≥1)
- N, 6, number of input words and select bits (2..32)
- CNT_W, 8, width of the error counter (≥1)

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  N*WIDTH  packed candidate words; word i is in_data[i*WIDTH +: WIDTH]
- in_sel  input  N  select vector; bit i selects word i
- in_valid  input  1  source presents a beat
- in_ready  output  1  block accepts the beat this cycle
- out_data  output  WIDTH  registered selected word
- out_err  output  1  registered flag: captured in_sel was not one-hot
- out_valid  output  1  out_data and out_err are valid
- out_ready  input  1  consumer accepts the output beat
- err_sticky  output  1  set by any accepted non-one-hot beat; held until err_clr
- err_count  output  CNT_W  saturating count of accepted non-one-hot beats
- err_clr  input  1  synchronous clear of err_sticky and err_count

## Operation
- Combinational select: sel_word = OR over i of (word i AND {WIDTH{in_sel[i]}}).
  - All-zero in_sel gives 0.
  - Multiple set bits give the bitwise OR of the selected words.
- in_ready = !out_valid || out_ready. This is combinational, with no path from in_valid.
- Accept: in_valid && in_ready.
  - On accept, out_data ← sel_word, out_err ← !onehot(in_sel), and out_valid ← 1.
- Drain: out_valid && out_ready && !accept. On drain, out_valid ← 0. out_data and out_err hold their values.
- Accept and drain in the same cycle: the new beat replaces the old one, and out_valid stays 1.
- No accept while out_valid is high and out_ready is low: out_data, out_err and out_valid all hold.
- Error tracking (updates on accept only):
  - err_sticky ← 1 when the accepted beat has out_err set.
  - err_count increments by 1 per such beat and saturates at 2^CNT_W−1.
- err_clr takes priority over an error on the same edge. Both err_sticky and err_count are cleared, and the coincident error is dropped.
- Reset mid-transfer discards any held beat. No partial state survives.

## Timing
- Latency is 1 cycle from accept to out_valid.
- Throughput is 1 beat per cycle while out_ready is high.
- Reset values, applied immediately on rst high:
  - out_valid = 0, out_data = 0, out_err = 0
  - err_sticky = 0, err_count = 0
  - in_ready = 1, which follows from out_valid = 0
- The first accept is possible on the first rising edge after rst is released.
- out_data, out_err and out_valid are driven directly from flops. in_ready is one gate from out_valid and out_ready.

## Configuration
- Macro: ONEHOT_MUX_CHECK_EN.
- Defined: the one-hot checker is instantiated. out_err, err_sticky and err_count behave as described above.
- Undefined: the checker and the error flops are not built.
  - out_err, err_sticky and err_count are tied to 0.
  - err_clr is ignored.
  - Data-path behaviour and timing are unchanged.

## Structure
- Package onehot_mux_pkg holds:
  - defaults ONEHOT_MUX_WIDTH_DEF = 4, ONEHOT_MUX_N_DEF = 6, ONEHOT_MUX_CNT_W_DEF = 8
  - the limit ONEHOT_MUX_N_MAX = 32
- Sub-module onehot_check (parameter N): input vec[N-1:0], output is_onehot.
  - is_onehot is true iff exactly one bit of vec is set.
  - Purely combinational; uses a popcount-free (v != 0) && ((v & (v−1)) == 0) form.
- Top level contains the AND-OR reduction, the output register stage, the handshake and the error counter. It is compiled with ONEHOT_MUX_CHECK_EN both defined and undefined.

## Test plan
All scenarios use defaults WIDTH=4, N=6, CNT_W=8, with ONEHOT_MUX_CHECK_EN defined unless stated.
- Reset and basic select: hold rst, then release. Check out_valid=0 and in_ready=1. Then drive in_data words {5:F,4:E,3:D,2:C,1:B,0:A}, in_sel=6'b001000 and in_valid=1. Next cycle expect out_data=D, out_err=0 and out_valid=1.
- Invalid selects:
  - in_sel=6'b000000: expect out_data=0, out_err=1, err_count=1.
  - in_sel=6'b000011 with words 0=4'h5 and 1=4'hA: expect out_data=F, out_err=1, err_count=2, err_sticky=1.
- Backpressure: hold out_ready=0 for 3 cycles with out_valid=1. Expect in_ready=0 and out_data held. Raise out_ready with a new beat present: the new beat is accepted the same cycle and out_valid stays 1.
- Counter behaviour: accept 300 non-one-hot beats and expect err_count=255. Assert err_clr together with a bad beat and expect err_count=0 and err_sticky=0 on the next cycle.
- Async reset mid-beat: assert rst between edges while out_valid=1. Expect out_valid=0 and err_count=0 before the next clock edge.
- Checker compiled out (ONEHOT_MUX_CHECK_EN undefined): drive in_sel=6'b000000. Expect out_data=0 and out_err=0, with err_count held at 0.
